lpddr5_cmd_sequencer: RTL and testbench

Command sequencer between the host-side request port and the LPDDR5 DRAM device model. It accepts one read or write request at a time and tracks the open row in each bank. It emits one-cycle ACT/RD/WR/PRE/REF commands, paced by the device's `dram_ready`. Periodic all-bank refresh is scheduled internally, and each request completes with a single response pulse.

---
 rtl/lpddr5_controller_enum.sv | 11 +
 rtl/lpddr5_params.sv | 7 +
 rtl/lpddr5_refresh_timer.sv | 29 ++
 rtl/lpddr5_cmd_sequencer.sv | 175 +++++++++++++++++
 tb/tb_lpddr5_cmd_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lpddr5_controller_enum.sv
// Device command encoding shared by the controller and the DRAM device model.
package lpddr5_controller_enum;
  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5
  } dram_cmd_t;
endpackage

// File: rtl/lpddr5_params.sv
// Shared LPDDR5 controller parameters: address width, bank count and the
// default refresh interval.
package lpddr5_params;
  localparam int ADDR_WIDTH   = 20;
  localparam int BANK_NUM     = 8;
  localparam int REFI_DEFAULT = 3900;
endpackage

// File: rtl/lpddr5_refresh_timer.sv
// Periodic refresh request generator: a down-counter that raises a sticky
// pending flag on every expiry until the sequencer clears it.
module lpddr5_refresh_timer #(
  parameter int REFI_CYCLES = 3900
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic pending
);
  localparam int CW = $clog2(REFI_CYCLES);
  localparam logic [CW-1:0] RELOAD = CW'(REFI_CYCLES - 1);

  logic [CW-1:0] count_r;

  // Expiry outranks a same-cycle clear so no refresh interval is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= RELOAD;
      pending <= 1'b0;
    end else if (count_r == {CW{1'b0}}) begin
      count_r <= RELOAD;
      pending <= 1'b1;
    end else begin
      count_r <= count_r - CW'(1);
      if (clear) pending <= 1'b0;
    end
  end
endmodule

// File: rtl/lpddr5_cmd_sequencer.sv
// Single-request LPDDR5 command sequencer: tracks open rows per bank, issues
// ACT/RD/WR/PRE/REF with a NOP settle after each, and schedules refresh.
module lpddr5_cmd_sequencer
  import lpddr5_params::*;
  import lpddr5_controller_enum::*;
#(
  parameter int CHANNELS     = 2,
  parameter int BURST_LENGTH = 16,
  parameter int DATA_BITS    = 32,
  parameter int ROW_LSB      = 10,
  parameter int REFI_CYCLES  = REFI_DEFAULT
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               req_valid,
  output logic                                               req_ready,
  input  logic                                               req_write,
  input  logic [ADDR_WIDTH-1:0]                              req_addr,
  input  logic [CHANNELS-1:0][DATA_BITS-1:0][BURST_LENGTH-1:0] req_wdata,
  output logic                                               rsp_valid,
  output logic                                               rsp_write,
  output logic [CHANNELS-1:0][DATA_BITS-1:0][BURST_LENGTH-1:0] rsp_rdata,
  output dram_cmd_t                                          dram_cmd,
  output logic [ADDR_WIDTH-1:0]                              dram_addr,
  output logic [CHANNELS-1:0][DATA_BITS-1:0][BURST_LENGTH-1:0] dram_wdata,
  input  logic [CHANNELS-1:0][DATA_BITS-1:0][BURST_LENGTH-1:0] dram_rdata,
  input  logic                                               dram_ready
);
  localparam int BANK_W = $clog2(BANK_NUM);
  localparam int ROW_W  = ADDR_WIDTH - ROW_LSB;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRE    = 3'd1,
    S_ACT    = 3'd2,
    S_CAS    = 3'd3,
    S_REFPRE = 3'd4,
    S_REF    = 3'd5,
    S_DONE   = 3'd6
  } seq_state_t;

  seq_state_t                                         state_r;
  logic [BANK_NUM-1:0]                                open_r;
  logic [ROW_W-1:0]                                   open_row_r [BANK_NUM];
  logic [ADDR_WIDTH-1:0]                              addr_r;
  logic                                               write_r;
  logic                                               ref_cycle_r;
  logic [CHANNELS-1:0][DATA_BITS-1:0][BURST_LENGTH-1:0] wdata_r;

  logic              ref_pending_s;
  logic              ref_clear_s;
  logic              can_issue_s;
  logic              accept_s;
  logic [BANK_W-1:0] req_bank_s;
  logic [BANK_W-1:0] cur_bank_s;
  logic [BANK_W-1:0] ref_bank_s;

  assign req_ready   = (state_r == S_IDLE) && !ref_pending_s && !rst;
  assign accept_s    = req_valid && req_ready;
  // dram_cmd holds last cycle's command, so this enforces the settle NOP.
  assign can_issue_s = dram_ready && (dram_cmd == CMD_NOP);
  assign req_bank_s  = req_addr[ADDR_WIDTH-1 -: BANK_W];
  assign cur_bank_s  = addr_r[ADDR_WIDTH-1 -: BANK_W];
  assign ref_clear_s = (state_r == S_REF) && can_issue_s;

  lpddr5_refresh_timer #(.REFI_CYCLES(REFI_CYCLES)) u_refresh_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (ref_clear_s),
    .pending (ref_pending_s)
  );

  // Lowest-index open bank, closed first during the refresh precharge sweep.
  always_comb begin
    ref_bank_s = {BANK_W{1'b0}};
    for (int i = BANK_NUM - 1; i >= 0; i--) begin
      if (open_r[i]) ref_bank_s = BANK_W'(i);
      else           ref_bank_s = ref_bank_s;
    end
  end

  // Sequencer state, bank table and registered device/response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      open_r      <= {BANK_NUM{1'b0}};
      for (int i = 0; i < BANK_NUM; i++) open_row_r[i] <= {ROW_W{1'b0}};
      addr_r      <= {ADDR_WIDTH{1'b0}};
      write_r     <= 1'b0;
      ref_cycle_r <= 1'b0;
      wdata_r     <= '0;
      dram_cmd    <= CMD_NOP;
      dram_addr   <= {ADDR_WIDTH{1'b0}};
      dram_wdata  <= '0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      dram_cmd  <= CMD_NOP;
      rsp_valid <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            addr_r  <= req_addr;
            write_r <= req_write;
            wdata_r <= req_wdata;
            if (!open_r[req_bank_s])
              state_r <= S_ACT;
            else if (open_row_r[req_bank_s] == req_addr[ADDR_WIDTH-1:ROW_LSB])
              state_r <= S_CAS;
            else
              state_r <= S_PRE;
          end else if (ref_pending_s) begin
            state_r <= S_REFPRE;
          end
        end
        S_PRE: begin
          if (can_issue_s) begin
            dram_cmd           <= CMD_PRE;
            dram_addr          <= {cur_bank_s, {(ADDR_WIDTH-BANK_W){1'b0}}};
            open_r[cur_bank_s] <= 1'b0;
            state_r            <= S_ACT;
          end
        end
        S_ACT: begin
          if (can_issue_s) begin
            dram_cmd               <= CMD_ACT;
            dram_addr              <= addr_r;
            open_r[cur_bank_s]     <= 1'b1;
            open_row_r[cur_bank_s] <= addr_r[ADDR_WIDTH-1:ROW_LSB];
            state_r                <= S_CAS;
          end
        end
        S_CAS: begin
          if (can_issue_s) begin
            dram_cmd    <= write_r ? CMD_WR : CMD_RD;
            dram_addr   <= addr_r;
            dram_wdata  <= wdata_r;
            ref_cycle_r <= 1'b0;
            state_r     <= S_DONE;
          end
        end
        S_REFPRE: begin
          if (open_r == {BANK_NUM{1'b0}}) begin
            state_r <= S_REF;
          end else if (can_issue_s) begin
            dram_cmd           <= CMD_PRE;
            dram_addr          <= {ref_bank_s, {(ADDR_WIDTH-BANK_W){1'b0}}};
            open_r[ref_bank_s] <= 1'b0;
          end
        end
        S_REF: begin
          if (can_issue_s) begin
            dram_cmd    <= CMD_REF;
            dram_addr   <= {ADDR_WIDTH{1'b0}};
            ref_cycle_r <= 1'b1;
            state_r     <= S_DONE;
          end
        end
        S_DONE: begin
          // Shared completion wait; a refresh finishes without a response.
          if (can_issue_s) begin
            if (!ref_cycle_r) begin
              rsp_valid <= 1'b1;
              rsp_write <= write_r;
              rsp_rdata <= dram_rdata;
            end
            state_r <= S_IDLE;
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lpddr5_cmd_sequencer.sv
// Self-checking bench: per-cycle comparison against a queue-based command
// model, directed scenarios with literal expectations, then random traffic.
module tb_lpddr5_cmd_sequencer;
  import lpddr5_params::*;
  import lpddr5_controller_enum::*;

  localparam int CH = 2, BL = 16, DB = 32, RL = 10, REFI = 64;
  localparam int AW = ADDR_WIDTH;
  localparam int BW = CH * DB * BL;
  localparam int BANK_W = $clog2(BANK_NUM);
  typedef logic [CH-1:0][DB-1:0][BL-1:0] burst_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  burst_t req_wdata = '0;
  logic rsp_valid, rsp_write;
  burst_t rsp_rdata;
  dram_cmd_t dram_cmd;
  logic [AW-1:0] dram_addr;
  burst_t dram_wdata;
  burst_t dram_rdata = '0;
  logic dram_ready = 1'b1;

  always #5 clk = ~clk;

  lpddr5_cmd_sequencer #(.CHANNELS(CH), .BURST_LENGTH(BL), .DATA_BITS(DB),
                         .ROW_LSB(RL), .REFI_CYCLES(REFI)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .dram_cmd(dram_cmd), .dram_addr(dram_addr), .dram_wdata(dram_wdata),
    .dram_rdata(dram_rdata), .dram_ready(dram_ready));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_burst(input string name, input burst_t act, input burst_t exp);
    logic [BW-1:0] fa, fe;
    fa = act;
    fe = exp;
    n_tests++;
    if (fa !== fe) begin
      n_fail++;
      $display("FAIL %s: got low64 %h expected low64 %h", name, fa[63:0], fe[63:0]);
    end
  endtask

  function automatic burst_t fill(input logic [31:0] seed);
    logic [BW-1:0] f;
    for (int k = 0; k < BW / 32; k++) f[k*32 +: 32] = seed * 32'h9E37_79B1 + 32'(k);
    return f;
  endfunction

  // ---------------- device stub: ready pattern, memory, command log -------
  int ready_mode = 0;   // 0 always ready, 1 random, 2 held low
  burst_t stub_mem [logic [AW-1:0]];
  typedef struct { dram_cmd_t cmd; logic [AW-1:0] addr; } cmd_rec_t;
  cmd_rec_t cmd_log[$];

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       dram_ready = 1'b1;
        1:       dram_ready = ($urandom_range(3) != 0);
        default: dram_ready = 1'b0;
      endcase
      if (dram_cmd == CMD_WR) stub_mem[dram_addr] = dram_wdata;
      else if (dram_cmd == CMD_RD) begin
        if (stub_mem.exists(dram_addr)) dram_rdata = stub_mem[dram_addr];
        else dram_rdata = fill(32'(dram_addr));
      end
      if (dram_cmd != CMD_NOP) cmd_log.push_back('{dram_cmd, dram_addr});
    end
  end

  // ---------------- behavioural model ------------------------------------
  // A request or refresh becomes a list of steps; each gated step fires when
  // the device is ready and the previous cycle carried no command.
  typedef enum { IT_CMD, IT_RSP, IT_END, IT_SKIP } it_kind_t;
  typedef struct { it_kind_t kind; dram_cmd_t cmd; logic [AW-1:0] addr; } item_t;
  item_t mq[$];
  bit m_open [BANK_NUM];
  int m_row [BANK_NUM];
  bit m_pend, m_write, m_clr, m_prev_nop;
  int m_edges, m_b, m_r;
  burst_t m_wdata;
  item_t m_it;
  dram_cmd_t e_cmd;
  logic [AW-1:0] e_addr;
  burst_t e_wdata, e_rdata;
  bit e_rsp, e_rspw;

  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      for (int i = 0; i < BANK_NUM; i++) m_open[i] = 1'b0;
      m_pend = 1'b0; m_edges = 0;
      e_cmd = CMD_NOP; e_addr = '0; e_wdata = '0; e_rdata = '0; e_rsp = 1'b0; e_rspw = 1'b0;
      chk("rst_dram_cmd", dram_cmd, CMD_NOP);
      chk("rst_dram_addr", dram_addr, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_write", rsp_write, 0);
      chk("rst_req_ready", req_ready, 0);
      chk_burst("rst_dram_wdata", dram_wdata, '0);
      chk_burst("rst_rsp_rdata", rsp_rdata, '0);
    end else begin
      chk("dram_cmd", dram_cmd, e_cmd);
      chk("dram_addr", dram_addr, e_addr);
      chk("rsp_valid", rsp_valid, e_rsp);
      chk("req_ready", req_ready, (mq.size() == 0) && !m_pend);
      chk_burst("dram_wdata", dram_wdata, e_wdata);
      if (e_rsp) chk("rsp_write", rsp_write, e_rspw);
      if (e_rsp && !e_rspw) chk_burst("rsp_rdata", rsp_rdata, e_rdata);

      m_prev_nop = (e_cmd == CMD_NOP);
      e_cmd = CMD_NOP;
      e_rsp = 1'b0;
      m_clr = 1'b0;
      if (mq.size() != 0) begin
        m_it = mq[0];
        if (m_it.kind == IT_SKIP) void'(mq.pop_front());
        else if (dram_ready && m_prev_nop) begin
          void'(mq.pop_front());
          case (m_it.kind)
            IT_CMD: begin
              e_cmd = m_it.cmd; e_addr = m_it.addr;
              if (m_it.cmd == CMD_RD || m_it.cmd == CMD_WR) e_wdata = m_wdata;
              if (m_it.cmd == CMD_REF) m_clr = 1'b1;
            end
            IT_RSP: begin e_rsp = 1'b1; e_rspw = m_write; e_rdata = dram_rdata; end
            default: ;
          endcase
        end
      end else if (req_valid && !m_pend) begin
        m_write = req_write; m_wdata = req_wdata;
        m_b = int'(req_addr >> (AW - BANK_W));
        m_r = int'(req_addr >> RL);
        if (m_open[m_b] && m_row[m_b] != m_r)
          mq.push_back('{IT_CMD, CMD_PRE, AW'(m_b) << (AW - BANK_W)});
        if (!m_open[m_b] || m_row[m_b] != m_r)
          mq.push_back('{IT_CMD, CMD_ACT, req_addr});
        mq.push_back('{IT_CMD, req_write ? CMD_WR : CMD_RD, req_addr});
        mq.push_back('{IT_RSP, CMD_NOP, '0});
        m_open[m_b] = 1'b1; m_row[m_b] = m_r;
      end else if (m_pend) begin
        for (int b = 0; b < BANK_NUM; b++) begin
          if (m_open[b]) mq.push_back('{IT_CMD, CMD_PRE, AW'(b) << (AW - BANK_W)});
          m_open[b] = 1'b0;
        end
        mq.push_back('{IT_SKIP, CMD_NOP, '0});
        mq.push_back('{IT_CMD, CMD_REF, '0});
        mq.push_back('{IT_END, CMD_NOP, '0});
      end
      m_edges++;
      if (m_clr) m_pend = 1'b0;
      if (m_edges % REFI == 0) m_pend = 1'b1;
    end
  end

  // ---------------- driver tasks -----------------------------------------
  burst_t ref_mem [logic [AW-1:0]];

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_cmd_nop", dram_cmd, CMD_NOP);
    chk("reset_addr_zero", dram_addr, 0);
    chk("reset_req_ready", req_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cmd_log.delete();
    @(negedge clk);
    chk("ready_after_release", req_ready, 1);
  endtask

  task automatic do_req(input bit w, input logic [AW-1:0] a, input burst_t d);
    int guard;
    guard = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    do begin @(negedge clk); guard++; end while (!req_ready && guard < 500);
    if (!req_ready) begin
      n_tests++; n_fail++;
      $display("FAIL handshake_timeout: addr %0h not accepted", a);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic txn(input bit w, input logic [AW-1:0] a, input burst_t d);
    int guard;
    burst_t exp;
    do_req(w, a, d);
    guard = 0;
    do begin @(negedge clk); guard++; end while (!rsp_valid && guard < 500);
    if (!rsp_valid) begin
      n_tests++; n_fail++;
      $display("FAIL rsp_timeout: addr %0h no response", a);
    end else begin
      chk("txn_rsp_write", rsp_write, w);
      if (w) ref_mem[a] = d;
      else begin
        exp = ref_mem.exists(a) ? ref_mem[a] : fill(32'(a));
        chk_burst("txn_read_data", rsp_rdata, exp);
      end
    end
  endtask

  task automatic chk_log(input int idx, input dram_cmd_t c, input logic [AW-1:0] a);
    if (idx >= cmd_log.size()) begin
      n_tests++; n_fail++;
      $display("FAIL log%0d: missing, expected cmd %0d addr %0h", idx, c, a);
    end else begin
      chk($sformatf("log%0d_cmd", idx), cmd_log[idx].cmd, c);
      chk($sformatf("log%0d_addr", idx), cmd_log[idx].addr, a);
    end
  endtask

  // ---------------- scenarios --------------------------------------------
  burst_t p1;
  int guard;

  initial begin
    p1 = fill(32'h1234_5678);
    do_reset();

    // closed-bank write then page-hit read
    txn(1'b1, 20'h00410, p1);
    txn(1'b0, 20'h00410, '0);
    chk("hit_log_len", cmd_log.size(), 3);
    chk_log(0, CMD_ACT, 20'h00410);
    chk_log(1, CMD_WR,  20'h00410);
    chk_log(2, CMD_RD,  20'h00410);
    chk_burst("hit_read_pattern", rsp_rdata, p1);

    // row conflict in bank 0
    do_reset();
    txn(1'b0, 20'h00400, '0);
    txn(1'b0, 20'h00800, '0);
    chk_log(0, CMD_ACT, 20'h00400);
    chk_log(1, CMD_RD,  20'h00400);
    chk_log(2, CMD_PRE, 20'h00000);
    chk_log(3, CMD_ACT, 20'h00800);
    chk_log(4, CMD_RD,  20'h00800);

    // device not ready for 10 cycles
    do_reset();
    ready_mode = 2;
    do_req(1'b0, 20'h00400, '0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_nop", dram_cmd, CMD_NOP);
    end
    #1 ready_mode = 0;
    @(negedge clk);
    chk("stall_release_nop", dram_cmd, CMD_NOP);
    @(negedge clk);
    chk("first_ready_act", dram_cmd, CMD_ACT);
    guard = 0;
    while (!rsp_valid && guard < 100) begin @(negedge clk); guard++; end
    chk("stall_rsp_seen", rsp_valid, 1);

    // refresh with banks 0 and 2 open
    do_reset();
    txn(1'b0, 20'h00400, '0);
    txn(1'b0, 20'h40400, '0);
    cmd_log.delete();
    guard = 0;
    while (cmd_log.size() < 3 && guard < 300) begin @(negedge clk); guard++; end
    chk_log(0, CMD_PRE, 20'h00000);
    chk_log(1, CMD_PRE, 20'h40000);
    chk_log(2, CMD_REF, 20'h00000);
    chk("ref_blocks_ready", req_ready, 0);
    cmd_log.delete();
    txn(1'b0, 20'h00400, '0);
    chk_log(0, CMD_ACT, 20'h00400);

    // reset in the cycle after ACT drops the request
    do_reset();
    do_req(1'b1, 20'h00410, fill(32'd7));
    guard = 0;
    while (dram_cmd != CMD_ACT && guard < 50) begin @(negedge clk); guard++; end
    chk("mid_reset_saw_act", dram_cmd, CMD_ACT);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_reset_nop", dram_cmd, CMD_NOP);
    chk("mid_reset_no_rsp", rsp_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cmd_log.delete();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("dropped_no_rsp", rsp_valid, 0);
    end
    txn(1'b0, 20'h00410, '0);
    chk_log(0, CMD_ACT, 20'h00410);

    // random traffic with a stuttering device
    ready_mode = 1;
    for (int n = 0; n < 150; n++) begin
      logic [AW-1:0] a;
      a = (AW'($urandom_range(BANK_NUM - 1)) << (AW - BANK_W)) |
          (AW'($urandom_range(3)) << RL) | (AW'($urandom_range(3)) << 4);
      repeat ($urandom_range(2)) @(posedge clk);
      txn(1'($urandom_range(1)), a, fill($urandom));
    end
    ready_mode = 0;
    repeat (5) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1, "watchdog expired");
  end
endmodule
